seq_detect_p: RTL and testbench
===============================

SEQ_DETECT_P -- requirements
Module: seq_detect_p

Interface
REQ-001 Parameter DW, default 4, symbol width in bits.
REQ-002 Parameter DEPTH, default 4, pattern length in symbols (2..16).
REQ-003 Parameter OVERLAP, default 1, where 1 means overlapping matches are allowed and 0 means the detector restarts after a match.
REQ-004 Parameter CNT_W, default 8, match counter width.
REQ-005 Parameter RST_PAT, default 16'h8431, reset pattern (DW*DEPTH bits); symbol 0 sits in the LSBs and is expected first, so the default order is 1,3,4,8.
REQ-006 Parameter TIMEOUT, default 8, idle-cycle limit used only when the timeout feature is compiled in.
REQ-007 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-008 Port rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-009 Port din_valid, input, 1 bit: din carries a symbol this cycle.
REQ-010 Port din, input, DW bits: input symbol.
REQ-011 Port pat_load, input, 1 bit: latch pat into the internal pattern register.
REQ-012 Port pat, input, DW*DEPTH bits: new pattern, same packing as RST_PAT.
REQ-013 Port cnt_clr, input, 1 bit: synchronous clear of match_cnt.
REQ-014 Port out, output, 1 bit: registered single-cycle match pulse.
REQ-015 Port busy, output, 1 bit: partial match in progress (idx != 0).
REQ-016 Port match_cnt, output, CNT_W bits: saturating count of matches.
REQ-017 Port tmo, output, 1 bit: registered single-cycle timeout pulse.

Function
REQ-018 The block SHALL hold a match index idx in the range 0..DEPTH-1 and a pattern register pat_r.
REQ-019 On a cycle with din_valid=1, pat_load=0 and din==pat_r[idx] with idx<DEPTH-1, idx SHALL increment.
REQ-020 On a valid symbol with idx==DEPTH-1 and din==pat_r[DEPTH-1] (a match), out SHALL be 1 in the cycle after that edge and then 0.
REQ-021 On a match, match_cnt SHALL increment.
REQ-022 On a match with OVERLAP=1, idx SHALL become (din==pat_r[0]) ? 1 : 0.
REQ-023 On a match with OVERLAP=0, idx SHALL become 0.
REQ-024 On a mismatching valid symbol, idx SHALL become (din==pat_r[0]) ? 1 : 0.
REQ-025 On a cycle with din_valid=0, idx SHALL hold (gaps are permitted), except as stated in REQ-035.
REQ-026 When pat_load=1: pat_r<=pat and idx<=0.
REQ-027 When pat_load=1, din in that cycle SHALL be discarded even if din_valid=1, and no match SHALL be possible that cycle.
REQ-028 match_cnt SHALL saturate at all-ones, with no wrap.
REQ-029 When cnt_clr=1, match_cnt<=0.
REQ-030 When cnt_clr=1 coincides with a match, match_cnt SHALL be 0; clear wins.
REQ-031 busy SHALL be registered and equal (idx != 0) with one cycle of latency relative to idx.
REQ-032 The block SHALL have no combinational path from inputs to outputs.

Reset
REQ-033 While rstn=0 (asynchronously): idx=0, pat_r=RST_PAT, out=0, busy=0, match_cnt=0, tmo=0, idle counter=0.
REQ-034 Reset asserted mid-sequence SHALL discard partial progress; the first valid symbol after rstn rises SHALL be compared against pat_r[0].

Configuration
REQ-035 With macro SEQ_DETECT_TIMEOUT_EN defined:
- An idle counter SHALL count consecutive din_valid=0 cycles while idx!=0.
- On reaching TIMEOUT: idx<=0, tmo=1 for one cycle, and the idle counter clears.
- Any valid symbol or pat_load SHALL clear the idle counter.
REQ-036 With SEQ_DETECT_TIMEOUT_EN undefined, there SHALL be no idle counter, tmo SHALL be tied to 0, and idx SHALL hold indefinitely across gaps.

Verification
REQ-037 Default parameters, reset released, valid stream 1,3,4,8 -> out=1 exactly one cycle after the edge sampling 8; match_cnt=1; busy high during 3,4,8.
REQ-038 Stream 1,3,6, then 1,1,3,4,8 -> no pulse on 6 (idx=0); the second 1 restarts at idx=1; one pulse after 8; match_cnt=1.
REQ-039 pat_load with pattern 8,1,2,8, then stream 8,1,2,8,1,2,8 -> two pulses with OVERLAP=1; one pulse with OVERLAP=0.
REQ-040 Stream 1,3, then rstn low for 1 cycle, then 4,8 -> no pulse; match_cnt=0; pattern back to 1,3,4,8.
REQ-041 Stream 1,3, then 8 idle cycles, then 4,8 -> with SEQ_DETECT_TIMEOUT_EN: tmo pulse on the 8th idle cycle and no match; without the macro: match pulse, tmo=0.
REQ-042 CNT_W=2, five matches, then cnt_clr asserted together with a sixth match -> match_cnt 1,2,3,3,3, then 0.

Source files
------------

// File: rtl/seq_detect_p.sv
// seq_detect_p: streaming detector for a DEPTH-symbol pattern with a saturating match counter.
// Optional idle timeout on partial matches is compiled in with `define SEQ_DETECT_TIMEOUT_EN.
module seq_detect_p #(
  parameter int                  DW      = 4,
  parameter int                  DEPTH   = 4,
  parameter int                  OVERLAP = 1,
  parameter int                  CNT_W   = 8,
  parameter logic [DW*DEPTH-1:0] RST_PAT = 16'h8431,
  parameter int                  TIMEOUT = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                din_valid,
  input  logic [DW-1:0]       din,
  input  logic                pat_load,
  input  logic [DW*DEPTH-1:0] pat,
  input  logic                cnt_clr,
  output logic                out,
  output logic                busy,
  output logic [CNT_W-1:0]    match_cnt,
  output logic                tmo
);

  localparam int             IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0]  LAST = IW'(DEPTH - 1);

  if (DEPTH < 2 || DEPTH > 16 || TIMEOUT < 1) begin : g_param_check
    $error("seq_detect_p: DEPTH must be 2..16 and TIMEOUT must be >= 1");
  end

  logic [DW*DEPTH-1:0] r_pat;
  logic [IW-1:0]       r_idx;
  logic                r_out;
  logic                r_busy;
  logic [CNT_W-1:0]    r_cnt;

  logic [DW-1:0]       w_sym [DEPTH];
  logic                w_hit;
  logic                w_first;
  logic                w_match;
  logic                w_tmo_hit;
  logic [IW-1:0]       w_idx_nxt;

  for (genvar g = 0; g < DEPTH; g++) begin : g_sym
    assign w_sym[g] = r_pat[g*DW +: DW];
  end

  assign w_hit   = (din == w_sym[r_idx]);
  assign w_first = (din == w_sym[0]);
  // A symbol arriving alongside pat_load is dropped, so it can never complete a match.
  assign w_match = din_valid && !pat_load && w_hit && (r_idx == LAST);

  always_comb begin
    w_idx_nxt = r_idx;
    if (pat_load) begin
      w_idx_nxt = '0;
    end else if (din_valid) begin
      if (w_hit && (r_idx != LAST)) begin
        w_idx_nxt = r_idx + 1'b1;
      end else if (w_hit && (OVERLAP == 0)) begin
        w_idx_nxt = '0;
      end else begin
        w_idx_nxt = w_first ? IW'(1) : '0;
      end
    end else if (w_tmo_hit) begin
      w_idx_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_idx  <= '0;
      r_pat  <= RST_PAT;
      r_out  <= 1'b0;
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_idx  <= w_idx_nxt;
      if (pat_load) begin
        r_pat <= pat;
      end
      r_out  <= w_match;
      // busy follows the current index, so it trails idx by one cycle
      r_busy <= (r_idx != '0);
      if (cnt_clr) begin
        r_cnt <= '0;
      end else if (w_match && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

`ifdef SEQ_DETECT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_idle;
  logic          r_tmo;

  assign w_tmo_hit = !pat_load && !din_valid && (r_idx != '0) && (r_idle == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_idle <= '0;
      r_tmo  <= 1'b0;
    end else begin
      if (pat_load || din_valid || (r_idx == '0) || w_tmo_hit) begin
        r_idle <= '0;
      end else begin
        r_idle <= r_idle + 1'b1;
      end
      r_tmo <= w_tmo_hit;
    end
  end

  assign tmo = r_tmo;
`else
  assign w_tmo_hit = 1'b0;
  assign tmo       = 1'b0;
`endif

  assign out       = r_out;
  assign busy      = r_busy;
  assign match_cnt = r_cnt;

endmodule

// File: tb/tb_seq_detect_p.sv
// Bench for seq_detect_p: default instance plus an OVERLAP=0 / CNT_W=2 instance on shared stimulus.
// Checks every cycle against an integer model, plus literal expectations for the directed scenarios.
module tb_seq_detect_p;

  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        din_valid = 1'b0;
  logic [3:0]  din = '0;
  logic        pat_load = 1'b0;
  logic [15:0] pat = 16'h0000;
  logic        cnt_clr = 1'b0;

  logic        out0, busy0, tmo0;
  logic [7:0]  cnt0;
  logic        out1, busy1, tmo1;
  logic [1:0]  cnt1;

  int n_checks = 0;
  int n_errors = 0;

  seq_detect_p u_dut0 (
    .clk(clk), .rstn(rstn), .din_valid(din_valid), .din(din),
    .pat_load(pat_load), .pat(pat), .cnt_clr(cnt_clr),
    .out(out0), .busy(busy0), .match_cnt(cnt0), .tmo(tmo0)
  );

  seq_detect_p #(.OVERLAP(0), .CNT_W(2)) u_dut1 (
    .clk(clk), .rstn(rstn), .din_valid(din_valid), .din(din),
    .pat_load(pat_load), .pat(pat), .cnt_clr(cnt_clr),
    .out(out1), .busy(busy1), .match_cnt(cnt1), .tmo(tmo1)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_pat [4] = '{1, 3, 4, 8};
  int m_idx [2] = '{0, 0};
  int m_cnt [2] = '{0, 0};
  int m_idle[2] = '{0, 0};
  bit m_out [2] = '{0, 0};
  bit m_busy[2] = '{0, 0};
  bit m_tmo [2] = '{0, 0};

  task automatic model_reset();
    m_pat = '{1, 3, 4, 8};
    for (int k = 0; k < 2; k++) begin
      m_idx[k] = 0; m_cnt[k] = 0; m_idle[k] = 0;
      m_out[k] = 0; m_busy[k] = 0; m_tmo[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit ov    = (k == 0);
      int cmax  = (k == 0) ? 255 : 3;
      bit match = 0;
      int ni    = m_idx[k];
      m_busy[k] = (m_idx[k] != 0);
      m_tmo[k]  = 0;
      if (pat_load) begin
        ni = 0;
      end else if (din_valid) begin
        if (int'(din) == m_pat[m_idx[k]] && m_idx[k] == 3) begin
          match = 1;
          ni = (ov && int'(din) == m_pat[0]) ? 1 : 0;
        end else if (int'(din) == m_pat[m_idx[k]]) begin
          ni = m_idx[k] + 1;
        end else begin
          ni = (int'(din) == m_pat[0]) ? 1 : 0;
        end
      end
`ifdef SEQ_DETECT_TIMEOUT_EN
      if (pat_load || din_valid || m_idx[k] == 0) begin
        m_idle[k] = 0;
      end else if (m_idle[k] == TIMEOUT - 1) begin
        m_idle[k] = 0;
        m_tmo[k] = 1;
        ni = 0;
      end else begin
        m_idle[k] = m_idle[k] + 1;
      end
`endif
      m_out[k] = match;
      if (cnt_clr) m_cnt[k] = 0;
      else if (match && m_cnt[k] < cmax) m_cnt[k] = m_cnt[k] + 1;
      m_idx[k] = ni;
    end
    if (pat_load) begin
      for (int j = 0; j < 4; j++) m_pat[j] = int'((pat >> (4 * j)) & 16'hF);
    end
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) model_reset();
    else model_step();
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("out0",  int'(out0),  int'(m_out[0]));
    chk("busy0", int'(busy0), int'(m_busy[0]));
    chk("cnt0",  int'(cnt0),  m_cnt[0]);
    chk("tmo0",  int'(tmo0),  int'(m_tmo[0]));
    chk("out1",  int'(out1),  int'(m_out[1]));
    chk("busy1", int'(busy1), int'(m_busy[1]));
    chk("cnt1",  int'(cnt1),  m_cnt[1]);
    chk("tmo1",  int'(tmo1),  int'(m_tmo[1]));
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit v, input int d, input bit ld, input bit clr);
    din_valid = v;
    din       = 4'(d);
    pat_load  = ld;
    cnt_clr   = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic sym(input int d);
    cyc(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic pulse_reset();
    rstn = 1'b0;
    idle();
    rstn = 1'b1;
  endtask

  task automatic full_match();
    sym(1); sym(3); sym(4); sym(8);
  endtask

  int exp_cnt1 [5] = '{1, 2, 3, 3, 3};
  int syms [5] = '{1, 3, 4, 8, 2};

  initial begin
    rstn = 1'b0;
    idle();
    idle();
    chk("rst_out", int'(out0), 0);
    chk("rst_cnt", int'(cnt0), 0);
    chk("rst_busy", int'(busy0), 0);
    rstn = 1'b1;
    idle();

    // Basic match 1,3,4,8
    sym(1);
    chk("m1_busy_after1", int'(busy0), 0);
    sym(3);
    chk("m1_busy_after3", int'(busy0), 1);
    sym(4);
    sym(8);
    chk("m1_out", int'(out0), 1);
    chk("m1_busy_after8", int'(busy0), 1);
    chk("m1_cnt", int'(cnt0), 1);
    idle();
    chk("m1_out_drop", int'(out0), 0);
    chk("m1_busy_drop", int'(busy0), 0);

    // Broken prefix then restart on a repeated first symbol
    sym(1); sym(3); sym(6);
    chk("m2_no_out", int'(out0), 0);
    sym(1); sym(1); sym(3); sym(4); sym(8);
    chk("m2_out", int'(out0), 1);
    chk("m2_cnt", int'(cnt0), 2);

    // Gaps inside a match are allowed
    sym(1); idle(); sym(3); idle(); idle(); sym(4); sym(8);
    chk("gap_out", int'(out0), 1);
    cyc(1'b0, 0, 1'b0, 1'b1);
    chk("clr_cnt0", int'(cnt0), 0);
    chk("clr_cnt1", int'(cnt1), 0);

    // New pattern 8,1,2,8: overlap vs restart
    pat = 16'h8218;
    cyc(1'b0, 0, 1'b1, 1'b0);
    sym(8); sym(1); sym(2); sym(8);
    chk("ov_first0", int'(out0), 1);
    chk("ov_first1", int'(out1), 1);
    sym(1); sym(2); sym(8);
    chk("ov_second0", int'(out0), 1);
    chk("ov_second1", int'(out1), 0);
    chk("ov_cnt0", int'(cnt0), 2);
    chk("ov_cnt1", int'(cnt1), 1);

    // Reset mid-sequence discards progress and restores the default pattern
    sym(8); sym(1);
    pulse_reset();
    sym(2); sym(8);
    chk("rst_mid_out_a", int'(out0), 0);
    sym(1); sym(3);
    pulse_reset();
    sym(4); sym(8);
    chk("rst_mid_out_b", int'(out0), 0);
    chk("rst_mid_cnt", int'(cnt0), 0);
    full_match();
    chk("rst_pat_back", int'(out0), 1);

    // Long idle gap inside a partial match
    sym(1); sym(3);
    for (int i = 0; i < 8; i++) idle();
`ifdef SEQ_DETECT_TIMEOUT_EN
    chk("tmo_pulse", int'(tmo0), 1);
`else
    chk("tmo_pulse", int'(tmo0), 0);
`endif
    sym(4); sym(8);
`ifdef SEQ_DETECT_TIMEOUT_EN
    chk("tmo_out", int'(out0), 0);
    chk("tmo_cnt", int'(cnt0), 1);
`else
    chk("tmo_out", int'(out0), 1);
    chk("tmo_cnt", int'(cnt0), 2);
`endif

    // Saturation on the 2-bit counter, then clear beats a coincident match
    cyc(1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      full_match();
      chk($sformatf("sat_cnt1_%0d", i), int'(cnt1), exp_cnt1[i]);
    end
    chk("sat_cnt0", int'(cnt0), 5);
    sym(1); sym(3); sym(4);
    cyc(1'b1, 8, 1'b0, 1'b1);
    chk("clr_win_out", int'(out1), 1);
    chk("clr_win_cnt1", int'(cnt1), 0);
    chk("clr_win_cnt0", int'(cnt0), 0);

    // Symbol coinciding with pat_load is discarded
    sym(1); sym(3); sym(4);
    pat = 16'h8431;
    cyc(1'b1, 8, 1'b1, 1'b0);
    chk("load_drop_out", int'(out0), 0);
    sym(8);
    chk("load_drop_after", int'(out0), 0);

    // Random traffic over the pattern alphabet, checked by the model
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 3) != 0), syms[$urandom_range(0, 4)], 1'b0,
          ($urandom_range(0, 39) == 0));
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
